// File: rtl/byte_frame_rx_pkg.sv
// Shared types for the byte_frame_rx parser: FSM states, buffer entry layout and default sync marker.
package byte_frame_rx_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CSUM,
        DROP
    } state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } entry_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/frame_rx_fifo.sv
// Payload buffer with speculative write pointer: frames become visible on commit, vanish on rollback.
module frame_rx_fifo
    import byte_frame_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  entry_t                 wr_entry,
    input  logic                   commit,
    input  logic                   rollback,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output entry_t                 rd_entry,
    output logic [$clog2(DEPTH):0] free_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] commit_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] used;
    logic          rd_fire;

    // Only committed entries are readable; speculative bytes sit between commit and write pointers.
    assign used     = commit_ptr_q - rd_ptr_q;
    assign free_cnt = PW'(DEPTH) - used;
    assign rd_valid = (used != '0);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_entry = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
        end else begin
            if (rollback) begin
                wr_ptr_q <= commit_ptr_q;
            end else if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (commit) begin
                commit_ptr_q <= wr_ptr_q;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/byte_frame_rx.sv
// Sync-hunting, length-prefixed frame receiver with XOR checksum; releases only verified payloads.
// Optional BYTE_FRAME_RX_STATS_EN adds saturating good/bad frame counters.
module byte_frame_rx
    import byte_frame_rx_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_DEFAULT,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned DEPTH     = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        frame_ok,
    output logic        frame_err
`ifdef BYTE_FRAME_RX_STATS_EN
    ,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
`endif
);

    state_e                 state_q, state_d;
    logic [8:0]             cnt_q, cnt_d;
    logic [7:0]             csum_q, csum_d;
    logic                   ok_d, err_d;
    logic                   wr_en, commit, rollback;
    entry_t                 wr_entry, rd_entry;
    logic [$clog2(DEPTH):0] free_cnt;
    logic                   len_bad, no_room;

    assign len_bad = (in_data == 8'd0) || (32'(in_data) > MAX_LEN);
    assign no_room = 32'(free_cnt) < 32'(in_data);

    frame_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_entry (wr_entry),
        .commit   (commit),
        .rollback (rollback),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_entry (rd_entry),
        .free_cnt (free_cnt)
    );

    assign out_data = rd_entry.data;
    assign out_last = rd_entry.last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            csum_q    <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                HUNT:    if (in_data == SYNC_BYTE) state_d = LEN;
                LEN: begin
                    if (len_bad)      state_d = HUNT;
                    else if (no_room) state_d = DROP;
                    else              state_d = PAYLOAD;
                end
                PAYLOAD: if (cnt_q == 9'd1) state_d = CSUM;
                CSUM:    state_d = HUNT;
                DROP:    if (cnt_q == 9'd1) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    // Datapath controls: buffer writes, checksum accumulation and commit/rollback decisions.
    always_comb begin
        cnt_d         = cnt_q;
        csum_d        = csum_q;
        ok_d          = 1'b0;
        err_d         = 1'b0;
        wr_en         = 1'b0;
        commit        = 1'b0;
        rollback      = 1'b0;
        wr_entry.last = (cnt_q == 9'd1);
        wr_entry.data = in_data;
        if (in_valid) begin
            case (state_q)
                LEN: begin
                    if (len_bad) begin
                        err_d = 1'b1;
                    end else if (no_room) begin
                        err_d = 1'b1;
                        cnt_d = 9'(in_data) + 9'd1;
                    end else begin
                        cnt_d  = 9'(in_data);
                        csum_d = in_data;
                    end
                end
                PAYLOAD: begin
                    wr_en  = 1'b1;
                    csum_d = csum_q ^ in_data;
                    cnt_d  = cnt_q - 9'd1;
                end
                CSUM: begin
                    if (in_data == csum_q) begin
                        commit = 1'b1;
                        ok_d   = 1'b1;
                    end else begin
                        rollback = 1'b1;
                        err_d    = 1'b1;
                    end
                end
                DROP:    cnt_d = cnt_q - 9'd1;
                default: ;
            endcase
        end
    end

`ifdef BYTE_FRAME_RX_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            if (frame_ok && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
            if (frame_err && (bad_cnt != 16'hFFFF)) bad_cnt <= bad_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_byte_frame_rx.sv
// Randomized self-checking bench for byte_frame_rx against a frame-level reference model.
module tb_byte_frame_rx;
    import byte_frame_rx_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_valid, a_last, a_ok, a_err;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_ok, b_err;
    logic [7:0] b_data;
    logic       m_valid, m_last, m_ok, m_err;
    logic [7:0] m_data;
    logic       sel16 = 1'b0;

`ifdef BYTE_FRAME_RX_STATS_EN
    logic [15:0] a_good, a_bad, b_good, b_bad;
`endif

    always #5 clk = ~clk;

    byte_frame_rx #(.SYNC_BYTE(8'hA5), .MAX_LEN(32), .DEPTH(64)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_last(a_last),
        .frame_ok(a_ok), .frame_err(a_err)
`ifdef BYTE_FRAME_RX_STATS_EN
        , .good_cnt(a_good), .bad_cnt(a_bad)
`endif
    );

    byte_frame_rx #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .DEPTH(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_last(b_last),
        .frame_ok(b_ok), .frame_err(b_err)
`ifdef BYTE_FRAME_RX_STATS_EN
        , .good_cnt(b_good), .bad_cnt(b_bad)
`endif
    );

    assign m_valid = sel16 ? b_valid : a_valid;
    assign m_data  = sel16 ? b_data  : a_data;
    assign m_last  = sel16 ? b_last  : a_last;
    assign m_ok    = sel16 ? b_ok    : a_ok;
    assign m_err   = sel16 ? b_err   : a_err;

    int         tests = 0;
    int         fails = 0;
    logic [8:0] exp_q [$];
    int         exp_ok, exp_err, seen_ok, seen_err;
    bit         both_seen;
    int         ready_mode;
    int         pat [4] = '{1, 0, 0, 1};
    int         pat_i;
    bit         hold_v;
    logic [8:0] hold_e;
    bit         smp_valid, smp_ok;
    int         cur_depth = 64;
    int         cur_max   = 32;

    task automatic clear_model();
        exp_q.delete();
        exp_ok = 0; exp_err = 0; seen_ok = 0; seen_err = 0;
        both_seen = 0; hold_v = 0; pat_i = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // One clock: drive inputs after the falling edge, observe and score the consumer side.
    task automatic do_cycle(input logic v, input logic [7:0] d);
        logic [8:0] e;
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ($urandom_range(3) != 0);
            default: begin out_ready = (pat[pat_i % 4] != 0); pat_i++; end
        endcase
        #1;
        smp_valid = m_valid;
        smp_ok    = m_ok;
        if (hold_v) begin
            tests++;
            if (m_valid !== 1'b1 || {m_last, m_data} !== hold_e) begin
                fails++;
                $display("FAIL stall_hold got=%0b/%0h exp=1/%0h", m_valid, {m_last, m_data}, hold_e);
            end
        end
        hold_v = m_valid && !out_ready;
        hold_e = {m_last, m_data};
        if (m_ok === 1'b1) seen_ok++;
        if (m_err === 1'b1) seen_err++;
        if (m_ok === 1'b1 && m_err === 1'b1) both_seen = 1;
        if (m_valid === 1'b1 && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out got=%0h exp=none", {m_last, m_data});
            end else begin
                e = exp_q.pop_front();
                if ({m_last, m_data} !== e) begin
                    fails++;
                    $display("FAIL out_byte got=%0h exp=%0h", {m_last, m_data}, e);
                end
            end
        end
    endtask

    task automatic gap(input bit en);
        if (en) repeat ($urandom_range(0, 2)) do_cycle(1'b0, 8'($urandom));
    endtask

    // Frame-level model: predicts commit, checksum error, bad length or no-room drop.
    task automatic send_frame(input int len, input bit good, input bit gaps);
        logic [7:0] pl [$];
        logic [7:0] cs;
        int         free;
        gap(gaps);
        do_cycle(1'b1, 8'hA5);
        gap(gaps);
        free = cur_depth - exp_q.size();
        do_cycle(1'b1, 8'(len));
        if (len == 0 || len > cur_max) begin
            exp_err++;
            return;
        end
        if (free < len) begin
            exp_err++;
            repeat (len + 1) begin
                gap(gaps);
                do_cycle(1'b1, 8'($urandom));
            end
            return;
        end
        cs = 8'(len);
        for (int i = 0; i < len; i++) begin
            pl.push_back(8'($urandom));
            cs ^= pl[i];
            gap(gaps);
            do_cycle(1'b1, pl[i]);
        end
        gap(gaps);
        if (good) begin
            do_cycle(1'b1, cs);
            for (int i = 0; i < len; i++) exp_q.push_back({1'(i == len - 1), pl[i]});
            exp_ok++;
        end else begin
            do_cycle(1'b1, cs ^ 8'($urandom_range(1, 255)));
            exp_err++;
        end
    endtask

    task automatic check_end(input string name);
        int guard = 0;
        ready_mode = 1;
        do_cycle(1'b0, 8'h00);
        do_cycle(1'b0, 8'h00);
        while (exp_q.size() != 0 && guard < 300) begin
            do_cycle(1'b0, 8'h00);
            guard++;
        end
        do_cycle(1'b0, 8'h00);
        tests++;
        if (exp_q.size() != 0) begin
            fails++; $display("FAIL %s_drain got=%0d left exp=0", name, exp_q.size());
        end
        tests++;
        if (m_valid !== 1'b0) begin
            fails++; $display("FAIL %s_idle_valid got=%0b exp=0", name, m_valid);
        end
        tests++;
        if (seen_ok != exp_ok) begin
            fails++; $display("FAIL %s_ok_count got=%0d exp=%0d", name, seen_ok, exp_ok);
        end
        tests++;
        if (seen_err != exp_err) begin
            fails++; $display("FAIL %s_err_count got=%0d exp=%0d", name, seen_err, exp_err);
        end
        tests++;
        if (both_seen) begin
            fails++; $display("FAIL %s_ok_err_same_cycle got=1 exp=0", name);
        end
`ifdef BYTE_FRAME_RX_STATS_EN
        tests++;
        if ((sel16 ? b_good : a_good) !== 16'(exp_ok) || (sel16 ? b_bad : a_bad) !== 16'(exp_err)) begin
            fails++;
            $display("FAIL %s_stats got=%0d/%0d exp=%0d/%0d", name,
                     sel16 ? b_good : a_good, sel16 ? b_bad : a_bad, exp_ok, exp_err);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if ({a_valid, a_data, a_last, a_ok, a_err} !== 12'h0) begin
            fails++; $display("FAIL reset_a got=%0h exp=0", {a_valid, a_data, a_last, a_ok, a_err});
        end
        tests++;
        if ({b_valid, b_data, b_last, b_ok, b_err} !== 12'h0) begin
            fails++; $display("FAIL reset_b got=%0h exp=0", {b_valid, b_data, b_last, b_ok, b_err});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        ready_mode = 1;
        repeat (3) do_cycle(1'b0, 8'hA5);
        check_end("reset");
    endtask

    task automatic test_good_frame();
        apply_reset();
        ready_mode = 1;
        do_cycle(1'b1, 8'hA5); do_cycle(1'b1, 8'h03);
        do_cycle(1'b1, 8'h11); do_cycle(1'b1, 8'h22); do_cycle(1'b1, 8'h33);
        do_cycle(1'b1, 8'h03);
        exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h133);
        exp_ok++;
        do_cycle(1'b0, 8'h00);
        tests++;
        if (smp_valid !== 1'b1 || smp_ok !== 1'b1) begin
            fails++; $display("FAIL good_latency got=%0b%0b exp=11", smp_valid, smp_ok);
        end
        check_end("good_frame");
    endtask

    task automatic test_bad_csum();
        apply_reset();
        ready_mode = 1;
        do_cycle(1'b1, 8'hA5); do_cycle(1'b1, 8'h03);
        do_cycle(1'b1, 8'h11); do_cycle(1'b1, 8'h22); do_cycle(1'b1, 8'h33);
        do_cycle(1'b1, 8'h04);
        exp_err++;
        send_frame(5, 1'b1, 1'b0);
        check_end("bad_csum");
    endtask

    task automatic test_bad_len();
        apply_reset();
        ready_mode = 1;
        do_cycle(1'b1, 8'hA5); do_cycle(1'b1, 8'h00);
        do_cycle(1'b1, 8'hA5); do_cycle(1'b1, 8'h01);
        do_cycle(1'b1, 8'h7E); do_cycle(1'b1, 8'h7F);
        exp_err++;
        exp_ok++;
        exp_q.push_back(9'h17E);
        send_frame(33, 1'b1, 1'b0);
        send_frame(32, 1'b1, 1'b0);
        check_end("bad_len");
    endtask

    task automatic test_no_room();
        apply_reset();
        sel16 = 1'b1; cur_depth = 16; cur_max = 16;
        ready_mode = 0;
        send_frame(12, 1'b1, 1'b1);
        send_frame(12, 1'b1, 1'b1);
        repeat (3) do_cycle(1'b0, 8'h00);
        tests++;
        if (exp_q.size() != 12 || m_valid !== 1'b1) begin
            fails++; $display("FAIL no_room_held got=%0d/%0b exp=12/1", exp_q.size(), m_valid);
        end
        tests++;
        if (seen_err != 1 || seen_ok != 1) begin
            fails++; $display("FAIL no_room_pulses got=%0d/%0d exp=1/1", seen_ok, seen_err);
        end
        check_end("no_room");
        sel16 = 1'b0; cur_depth = 64; cur_max = 32;
    endtask

    task automatic test_backpressure();
        apply_reset();
        ready_mode = 3;
        send_frame(7, 1'b1, 1'b0);
        send_frame(3, 1'b1, 1'b1);
        repeat (12) do_cycle(1'b0, 8'h00);
        check_end("backpressure");
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        ready_mode = 0;
        send_frame(4, 1'b1, 1'b0);
        do_cycle(1'b1, 8'hA5); do_cycle(1'b1, 8'h03); do_cycle(1'b1, 8'h11);
        tests++;
        if (m_valid !== 1'b1) begin
            fails++; $display("FAIL pre_reset_valid got=%0b exp=1", m_valid);
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({m_valid, m_data, m_last, m_ok, m_err} !== 12'h0) begin
            fails++; $display("FAIL mid_reset_outputs got=%0h exp=0", {m_valid, m_data, m_last, m_ok, m_err});
        end
        @(negedge clk);
        reset = 1'b0;
        clear_model();
        ready_mode = 1;
        do_cycle(1'b1, 8'hA5); do_cycle(1'b1, 8'h01);
        do_cycle(1'b1, 8'h55); do_cycle(1'b1, 8'h54);
        exp_q.push_back(9'h155);
        exp_ok++;
        check_end("reset_mid");
    endtask

    task automatic test_random();
        int r, len;
        logic [7:0] junk;
        apply_reset();
        ready_mode = 2;
        for (int f = 0; f < 60; f++) begin
            repeat ($urandom_range(0, 2)) begin
                junk = 8'($urandom);
                if (junk == 8'hA5) junk = 8'h00;
                do_cycle(1'b1, junk);
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                len = ($urandom_range(1) == 0) ? 0 : $urandom_range(33, 255);
                send_frame(len, 1'b1, 1'b1);
            end else begin
                len = $urandom_range(1, 32);
                send_frame(len, (r > 2), 1'b1);
            end
        end
        check_end("random");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_len();
        test_no_room();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/byte_frame_rx.md
Name: byte_frame_rx

Overview:
- Downstream consumer of the 8-bit registered byte stream produced by the DUT flop stage.
- Hunts for a sync byte, then parses a length-prefixed frame and checks an XOR checksum.
- Payload bytes of good frames are released through a valid/ready output with a last marker.
- Bad or oversize frames are discarded completely; no partial frame ever reaches the output.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 32, largest legal payload length (1..255).
- DEPTH, 64, payload buffer entries; power of two, DEPTH >= MAX_LEN.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data holds a byte this cycle; there is no backpressure on the input.
- in_data  input  8  stream byte.
- out_valid  output  1  out_data/out_last valid.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
- out_data  output  8  payload byte.
- out_last  output  1  final payload byte of a frame.
- frame_ok  output  1  one-cycle pulse when a frame commits.
- frame_err  output  1  one-cycle pulse on a bad length, bad checksum or no-room drop.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset: all outputs 0, state HUNT, all buffer pointers 0. Reset mid-frame discards uncommitted data; committed but unread data is also lost.
- Input bytes are examined only when in_valid=1. Idle cycles never change state.
- HUNT: in_data==SYNC_BYTE -> LEN. Any other byte is ignored.
- LEN:
  - Byte L is 0 or > MAX_LEN -> frame_err, go to HUNT. That byte is not re-examined as sync.
  - Free space (DEPTH - (commit_ptr - rd_ptr)) < L -> frame_err, go to DROP with cnt=L+1.
  - Otherwise csum=L, cnt=L, go to PAYLOAD.
- PAYLOAD:
  - Each byte is written at wr_ptr with its last bit set when cnt==1.
  - csum ^= byte, cnt--. Go to CSUM when cnt reaches 0.
- CSUM:
  - Byte == csum -> commit_ptr <= wr_ptr, frame_ok pulse.
  - Otherwise wr_ptr <= commit_ptr (rollback), frame_err pulse.
  - Both cases return to HUNT.
- DROP: consume cnt bytes without writing them, then go to HUNT.
- Output side sees only entries in [rd_ptr, commit_ptr).
- Latency: out_valid rises the cycle after the edge that samples a good checksum byte.
- out_data, out_last and out_valid are held stable while out_valid && !out_ready.
- Reads may proceed concurrently with writes, commit and rollback. Commit and a read in the same cycle are both honoured.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. The buffer is full when commit_ptr - rd_ptr == DEPTH.
- frame_ok and frame_err are never asserted in the same cycle.

Optional Feature:
- Macro: BYTE_FRAME_RX_STATS_EN.
- Defined:
  - Adds outputs good_cnt[15:0] and bad_cnt[15:0], reset to 0.
  - They increment on frame_ok and frame_err respectively and saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package byte_frame_rx_pkg holds:
  - the state enum {HUNT, LEN, PAYLOAD, CSUM, DROP};
  - typedef entry_t = struct {logic last; logic [7:0] data;};
  - the default SYNC constant.
- Sub-module frame_rx_fifo is a commit/rollback FIFO with:
  - inputs wr_en, wr_entry, commit, rollback;
  - read port rd_valid/rd_ready/rd_entry;
  - output free_cnt.
- The parser FSM lives in the top level.

Test Plan:
- Good frame: A5 03 11 22 33 03 with out_ready=1 -> frame_ok pulse, output 11,22,33 with out_last on 33, frame_err stays 0.
- Bad checksum: A5 03 11 22 33 04 -> frame_err pulse, out_valid never rises. A following good frame is output intact.
- Bad length: A5 00 A5 01 7E 7F -> frame_err on 00, then frame_ok and a single byte 7E with out_last=1.
- No room: DEPTH=16, MAX_LEN=16, out_ready=0, two frames of LEN 12 -> first commits, second gives frame_err and is dropped. Raising out_ready yields exactly 12 bytes.
- Backpressure: good frame with out_ready toggling 1,0,0,1 -> data held stable while stalled, order preserved, no loss.
- Reset mid-frame: assert reset after A5 03 11 -> outputs 0 immediately. After release, frame A5 01 55 54 outputs 55 only.
